// File: rtl/md_unit.sv
// Multiply/divide unit that owns the HI/LO registers. A down-counter models the
// multi-cycle latency. Define MD_MADD_EN to enable the multiply-accumulate family.
module md_unit #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] MULT_LAT_C = 4'(MULT_LAT);
  localparam logic [3:0] DIV_LAT_C  = 4'(DIV_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start_ok;
  logic        is_div_op;
  logic [3:0]  lat;

  // Datapath results, all derived from the captured operands.
  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] prod_s, prod_u;
  logic        [31:0] div_b;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;
  logic               div_ovf;
  logic        [63:0] result;
  logic               result_wr;

  always_comb begin
    a_sx    = {{32{a_q[31]}}, a_q};
    b_sx    = {{32{b_q[31]}}, b_q};
    prod_s  = 64'(a_sx * b_sx);
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    // A zero divisor is replaced so the dividers never see it; the write is suppressed below.
    div_b   = (b_q == 32'd0) ? 32'd1 : b_q;
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    quot_s  = div_ovf ? a_q   : 32'($signed(a_q) / $signed(div_b));
    rem_s   = div_ovf ? 32'd0 : 32'($signed(a_q) % $signed(div_b));
    quot_u  = a_q / div_b;
    rem_u   = a_q % div_b;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result    = {hi_q, lo_q};
    result_wr = 1'b1;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        result    = {rem_s, quot_s};
        result_wr = (b_q != 32'd0);
      end
      OP_DIVU: begin
        result    = {rem_u, quot_u};
        result_wr = (b_q != 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD:  result = {hi_q, lo_q} + prod_s;
      OP_MADDU: result = {hi_q, lo_q} + prod_u;
      OP_MSUB:  result = {hi_q, lo_q} - prod_s;
      OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
      default:  result_wr = 1'b0;
    endcase
  end

  always_comb begin
    is_div_op = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    lat       = is_div_op ? DIV_LAT_C : MULT_LAT_C;
    case (MDOp)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_ok = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_ok = 1'b1;
`endif
      default: start_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start && start_ok) begin
          state_d = RUN;
          cnt_d   = lat;
          op_d    = MDOp;
          a_d     = A;
          b_d     = B;
          busy_d  = 1'b1;
        end else if (!Start && MDOp == OP_MTHI) begin
          hi_d = A;
        end else if (!Start && MDOp == OP_MTLO) begin
          lo_d = A;
        end
      end
      RUN: begin
        // Start and MTHI/MTLO are deliberately not looked at while running.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          if (result_wr) {hi_d, lo_d} = result;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: operand/opcode holding registers are reset too, so a reset mid-operation
      // leaves nothing that could be written back later.
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit; the MD_MADD_EN build also runs the accumulate tests.
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a Start pulse and count the negedges on which Busy is seen high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0; A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A;
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    Start = 1'b0; MDOp = op; A = v;
    @(negedge clk);
    MDOp = 4'd0; A = 32'd0;
  endtask

  task automatic test_reset();
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: Busy=%b HI=%h LO=%h, expected 0/0/0", Busy, HI, LO);
    end
  endtask

  task automatic test_mult();
    int cyc;
    run_op(4'd1, 32'd3, 32'hFFFF_FFFE, cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL mult_latency: got %0d cycles, expected 5", cyc); end
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_result: HI=%h LO=%h, expected ffffffff/fffffffa", HI, LO);
    end
  endtask

  task automatic test_div();
    int cyc;
    run_op(4'd4, 32'd7, 32'd2, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL divu_latency: got %0d cycles, expected 10", cyc); end
    checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      errors++; $display("FAIL divu_result: HI=%h LO=%h, expected 1/3", HI, LO);
    end
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg: HI=%h LO=%h, expected ffffffff/fffffffd", HI, LO);
    end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf: HI=%h LO=%h, expected 0/80000000", HI, LO);
    end
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checks++;
    if (HI !== 32'd0 || LO !== 32'd1) begin
      errors++; $display("FAIL mult_neg_neg: HI=%h LO=%h, expected 0/1", HI, LO);
    end
  endtask

  task automatic test_mt_div0();
    int cyc;
    move_to(4'd5, 32'h1234);
    move_to(4'd6, 32'h5678);
    checks++;
    if (HI !== 32'h1234 || LO !== 32'h5678) begin
      errors++; $display("FAIL mthi_mtlo: HI=%h LO=%h, expected 1234/5678", HI, LO);
    end
    // Start with a non-arithmetic code must not launch anything.
    run_op(4'd5, 32'hDEAD, 32'd1, cyc);
    checks++;
    if (cyc !== 0 || HI !== 32'h1234) begin
      errors++; $display("FAIL start_mthi_ignored: cyc=%0d HI=%h, expected 0/1234", cyc, HI);
    end
    run_op(4'd3, 32'd99, 32'd0, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL div0_latency: got %0d cycles, expected 10", cyc); end
    checks++;
    if (HI !== 32'h1234 || LO !== 32'h5678) begin
      errors++; $display("FAIL div0_hold: HI=%h LO=%h, expected 1234/5678", HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    Start = 1'b1; MDOp = 4'd2; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clk);                        // busy cycle 1
    Start = 1'b0; MDOp = 4'd0;
    cyc = (Busy === 1'b1) ? 1 : 0;
    @(negedge clk);                        // busy cycle 2: restart attempt
    if (Busy === 1'b1) cyc++;
    Start = 1'b1; MDOp = 4'd1; A = 32'd1; B = 32'd1;
    @(negedge clk);                        // busy cycle 3: MTLO attempt
    if (Busy === 1'b1) cyc++;
    Start = 1'b0; MDOp = 4'd6; A = 32'hBEEF;
    @(negedge clk);
    MDOp = 4'd0; A = 32'd0; B = 32'd0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL busy_ignore_latency: got %0d cycles, expected 5", cyc); end
    checks++;
    if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
      errors++; $display("FAIL busy_ignore_result: HI=%h LO=%h, expected fffffffe/00000001", HI, LO);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL no_restart: Busy=%b, expected 0", Busy); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    Start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    repeat (3) @(negedge clk);             // now in busy cycle 4
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_async: Busy=%b HI=%h LO=%h, expected 0/0/0", Busy, HI, LO);
    end
    #1 reset_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_no_write: Busy=%b HI=%h LO=%h, expected 0/0/0", Busy, HI, LO);
    end
  endtask

  task automatic test_madd();
    int cyc;
    move_to(4'd5, 32'd0);
    move_to(4'd6, 32'd10);
    run_op(4'd7, 32'd2, 32'd3, cyc);
`ifdef MD_MADD_EN
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL madd_latency: got %0d cycles, expected 5", cyc); end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd16) begin
      errors++; $display("FAIL madd_result: HI=%h LO=%h, expected 0/16", HI, LO);
    end
    run_op(4'd10, 32'd1, 32'd17, cyc);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL msubu_result: HI=%h LO=%h, expected ffffffff/ffffffff", HI, LO);
    end
`else
    checks++;
    if (cyc !== 0 || Busy !== 1'b0) begin
      errors++; $display("FAIL madd_disabled_busy: cyc=%0d Busy=%b, expected 0/0", cyc, Busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (HI !== 32'd0 || LO !== 32'd10) begin
      errors++; $display("FAIL madd_disabled_hold: HI=%h LO=%h, expected 0/10", HI, LO);
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0; Start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
    #12;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_mult();
    test_div();
    test_mt_div0();
    test_back_to_back();
    test_reset_mid_op();
    test_madd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
